// File: rtl/puf_response_collector_if.sv
// Readout handshake between the PUF response collector and its consumer.
// The collector drives the assembled word; the consumer acknowledges it with resp_ready.
interface puf_response_collector_if;
   logic [15:0] resp_data;
   logic        resp_valid;
   logic        resp_ready;

   modport master (output resp_data, output resp_valid, input resp_ready);
   modport slave  (input resp_data, input resp_valid, output resp_ready);
endinterface

// File: rtl/puf_response_collector.sv
// Steps the 16:1 response mux through all arbiter outputs, majority-votes each bit
// and presents the assembled 16-bit PUF response over a valid/ready handshake.
module puf_response_collector_param_chk #(
   parameter int SETTLE_CYCLES = 2,
   parameter int VOTES         = 5
) ();
   if ((VOTES < 1) || ((VOTES % 2) == 0)) begin : g_bad_votes
      $error("puf_response_collector: VOTES must be odd and >= 1");
   end
   if (SETTLE_CYCLES < 0) begin : g_bad_settle
      $error("puf_response_collector: SETTLE_CYCLES must be >= 0");
   end
endmodule

module puf_response_collector #(
   parameter int SETTLE_CYCLES = 2,
   parameter int VOTES         = 5
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       abort,
   output logic [3:0]                 mux_sel,
   input  logic                       mux_out,
   output logic                       busy,
   puf_response_collector_if.master   rsp
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int VW = (VOTES > 1) ? $clog2(VOTES) : 1;
   localparam int OW = $clog2(VOTES + 1);

   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
   localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);
   localparam logic [OW-1:0] VOTE_HALF   = OW'(VOTES / 2);
   // With no settle time every bit goes straight into sampling.
   localparam logic [1:0]    S_FIRST     = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

   puf_response_collector_param_chk #(.SETTLE_CYCLES(SETTLE_CYCLES), .VOTES(VOTES)) u_param_chk ();

   function automatic logic majority(input logic [OW-1:0] ones);
      return (ones > VOTE_HALF);
   endfunction

   logic [1:0]    state_r,      state_nxt_s;
   logic [3:0]    mux_sel_r,    mux_sel_nxt_s;
   logic [SW-1:0] settle_cnt_r, settle_cnt_nxt_s;
   logic [VW-1:0] vote_cnt_r,   vote_cnt_nxt_s;
   logic [OW-1:0] ones_r,       ones_nxt_s;
   logic [OW-1:0] ones_sum_s;
   logic [15:0]   shadow_r,     shadow_nxt_s;
   logic [15:0]   resp_data_r,  resp_data_nxt_s;
   logic          resp_valid_r, resp_valid_nxt_s;
   logic          busy_r,       busy_nxt_s;

   assign ones_sum_s     = ones_r + OW'(mux_out);
   assign mux_sel        = mux_sel_r;
   assign busy           = busy_r;
   assign rsp.resp_data  = resp_data_r;
   assign rsp.resp_valid = resp_valid_r;

   // Next-state logic; abort outranks both sample completion and the handshake.
   always_comb begin
      state_nxt_s      = state_r;
      mux_sel_nxt_s    = mux_sel_r;
      settle_cnt_nxt_s = settle_cnt_r;
      vote_cnt_nxt_s   = vote_cnt_r;
      ones_nxt_s       = ones_r;
      shadow_nxt_s     = shadow_r;
      resp_data_nxt_s  = resp_data_r;
      resp_valid_nxt_s = resp_valid_r;
      busy_nxt_s       = busy_r;
      if (abort && (state_r != S_IDLE)) begin
         state_nxt_s      = S_IDLE;
         mux_sel_nxt_s    = 4'd0;
         settle_cnt_nxt_s = {SW{1'b0}};
         vote_cnt_nxt_s   = {VW{1'b0}};
         ones_nxt_s       = {OW{1'b0}};
         shadow_nxt_s     = 16'h0000;
         resp_valid_nxt_s = 1'b0;
         busy_nxt_s       = 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start && !abort) begin
                  state_nxt_s      = S_FIRST;
                  mux_sel_nxt_s    = 4'd0;
                  settle_cnt_nxt_s = {SW{1'b0}};
                  vote_cnt_nxt_s   = {VW{1'b0}};
                  ones_nxt_s       = {OW{1'b0}};
                  shadow_nxt_s     = 16'h0000;
                  busy_nxt_s       = 1'b1;
               end else begin
                  state_nxt_s = S_IDLE;
               end
            end
            S_SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  state_nxt_s      = S_SAMPLE;
                  settle_cnt_nxt_s = {SW{1'b0}};
               end else begin
                  settle_cnt_nxt_s = settle_cnt_r + SW'(1);
               end
            end
            S_SAMPLE: begin
               if (vote_cnt_r == VOTE_LAST) begin
                  // The final sample is part of the vote, hence ones_sum_s.
                  shadow_nxt_s[mux_sel_r] = majority(ones_sum_s);
                  vote_cnt_nxt_s          = {VW{1'b0}};
                  ones_nxt_s              = {OW{1'b0}};
                  if (mux_sel_r == 4'd15) begin
                     resp_data_nxt_s  = shadow_nxt_s;
                     resp_valid_nxt_s = 1'b1;
                     state_nxt_s      = S_DONE;
                  end else begin
                     mux_sel_nxt_s    = mux_sel_r + 4'd1;
                     settle_cnt_nxt_s = {SW{1'b0}};
                     state_nxt_s      = S_FIRST;
                  end
               end else begin
                  vote_cnt_nxt_s = vote_cnt_r + VW'(1);
                  ones_nxt_s     = ones_sum_s;
               end
            end
            S_DONE: begin
               if (rsp.resp_ready) begin
                  state_nxt_s      = S_IDLE;
                  resp_valid_nxt_s = 1'b0;
                  busy_nxt_s       = 1'b0;
                  mux_sel_nxt_s    = 4'd0;
               end else begin
                  state_nxt_s = S_DONE;
               end
            end
            default: begin
               state_nxt_s      = S_IDLE;
               mux_sel_nxt_s    = 4'd0;
               resp_valid_nxt_s = 1'b0;
               busy_nxt_s       = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= S_IDLE;
         mux_sel_r    <= 4'd0;
         settle_cnt_r <= {SW{1'b0}};
         vote_cnt_r   <= {VW{1'b0}};
         ones_r       <= {OW{1'b0}};
         shadow_r     <= 16'h0000;
         resp_data_r  <= 16'h0000;
         resp_valid_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         mux_sel_r    <= mux_sel_nxt_s;
         settle_cnt_r <= settle_cnt_nxt_s;
         vote_cnt_r   <= vote_cnt_nxt_s;
         ones_r       <= ones_nxt_s;
         shadow_r     <= shadow_nxt_s;
         resp_data_r  <= resp_data_nxt_s;
         resp_valid_r <= resp_valid_nxt_s;
         busy_r       <= busy_nxt_s;
      end
   end
endmodule

// File: tb/tb_puf_response_collector.sv
// Bench for puf_response_collector: vector table, random passes against a timing/majority
// model, abort and async reset sequences, and a SETTLE_CYCLES=0 / VOTES=1 instance.
module tb_puf_response_collector;
   localparam int S0 = 2;
   localparam int V0 = 5;
   localparam int BIT_T = S0 + V0;
   localparam int PASS_T = 16 * BIT_T;

   typedef struct {
      logic [15:0] votes [5];
      logic [15:0] exp;
      int          ready_delay;
      int          abort_at;
      int          rst_at;
      bit          start_hold;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start0 = 1'b0, abort0 = 1'b0, mux_out0 = 1'b0;
   logic start1 = 1'b0, abort1 = 1'b0, mux_out1 = 1'b0;
   logic [3:0] mux_sel0, mux_sel1;
   logic busy0, busy1;
   int total = 0;
   int bad = 0;
   logic [15:0] model_resp = 16'h0000;

   puf_response_collector_if rsp0 ();
   puf_response_collector_if rsp1 ();

   puf_response_collector #(.SETTLE_CYCLES(S0), .VOTES(V0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort0),
      .mux_sel(mux_sel0), .mux_out(mux_out0), .busy(busy0), .rsp(rsp0));

   puf_response_collector #(.SETTLE_CYCLES(0), .VOTES(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1),
      .mux_sel(mux_sel1), .mux_out(mux_out1), .busy(busy1), .rsp(rsp1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                               input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] e,
                               input int rd, input int ab, input int rs, input bit sh);
      vec_t r;
      r.votes[0] = w0; r.votes[1] = w1; r.votes[2] = w2; r.votes[3] = w3; r.votes[4] = w4;
      r.exp = e; r.ready_delay = rd; r.abort_at = ab; r.rst_at = rs; r.start_hold = sh;
      return r;
   endfunction

   // Reference: each bit is 1 when more than half of its samples are 1.
   function automatic logic [15:0] maj_word(input vec_t v);
      logic [15:0] w;
      for (int b = 0; b < 16; b++) begin
         int cnt;
         cnt = 0;
         for (int s = 0; s < V0; s++) cnt += int'(v.votes[s][b]);
         w[b] = (2 * cnt > V0);
      end
      return w;
   endfunction

   task automatic run_pass(input vec_t v, input string tag);
      start0 = 1'b1; abort0 = 1'b0; rsp0.resp_ready = 1'b0; mux_out0 = 1'($urandom);
      tick();
      if (!v.start_hold) start0 = 1'b0;
      chk({tag, " start busy"}, 32'(busy0), 32'd1);
      chk({tag, " start sel"}, 32'(mux_sel0), 32'd0);
      for (int t = 1; t <= PASS_T; t++) begin
         int bi, ph;
         bi = (t - 1) / BIT_T;
         ph = (t - 1) % BIT_T;
         mux_out0 = (ph >= S0) ? v.votes[ph - S0][bi] : 1'($urandom);
         abort0 = (t == v.abort_at);
         tick();
         if (t == v.abort_at) begin
            abort0 = 1'b0; start0 = 1'b0;
            chk({tag, " abort sel"}, 32'(mux_sel0), 32'd0);
            chk({tag, " abort busy"}, 32'(busy0), 32'd0);
            chk({tag, " abort valid"}, 32'(rsp0.resp_valid), 32'd0);
            chk({tag, " abort data"}, 32'(rsp0.resp_data), 32'(model_resp));
            tick();
            chk({tag, " abort stays idle"}, 32'(busy0), 32'd0);
            return;
         end
         chk({tag, " sel"}, 32'(mux_sel0), (t == PASS_T) ? 32'd15 : 32'(t / BIT_T));
         chk({tag, " busy"}, 32'(busy0), 32'd1);
         chk({tag, " valid"}, 32'(rsp0.resp_valid), 32'(t == PASS_T));
         chk({tag, " data"}, 32'(rsp0.resp_data), (t == PASS_T) ? 32'(v.exp) : 32'(model_resp));
         if (t == v.rst_at) begin
            #3 reset_n = 1'b0;
            #1;
            start0 = 1'b0;
            chk({tag, " rst sel"}, 32'(mux_sel0), 32'd0);
            chk({tag, " rst busy"}, 32'(busy0), 32'd0);
            chk({tag, " rst valid"}, 32'(rsp0.resp_valid), 32'd0);
            chk({tag, " rst data"}, 32'(rsp0.resp_data), 32'd0);
            model_resp = 16'h0000;
            tick();
            reset_n = 1'b1;
            tick();
            chk({tag, " post-rst busy"}, 32'(busy0), 32'd0);
            return;
         end
      end
      model_resp = v.exp;
      for (int d = 0; d < v.ready_delay; d++) begin
         mux_out0 = 1'($urandom);
         tick();
         chk({tag, " hold valid"}, 32'(rsp0.resp_valid), 32'd1);
         chk({tag, " hold data"}, 32'(rsp0.resp_data), 32'(v.exp));
         chk({tag, " hold sel"}, 32'(mux_sel0), 32'd15);
      end
      rsp0.resp_ready = 1'b1;
      tick();
      rsp0.resp_ready = 1'b0;
      chk({tag, " hs valid"}, 32'(rsp0.resp_valid), 32'd0);
      chk({tag, " hs busy"}, 32'(busy0), 32'd0);
      chk({tag, " hs sel"}, 32'(mux_sel0), 32'd0);
      chk({tag, " hs data"}, 32'(rsp0.resp_data), 32'(v.exp));
      if (v.start_hold) begin
         // start still high: taken only now that the collector is back in IDLE
         tick();
         chk({tag, " restart busy"}, 32'(busy0), 32'd1);
         start0 = 1'b0; abort0 = 1'b1;
         tick();
         abort0 = 1'b0;
         chk({tag, " restart abort busy"}, 32'(busy0), 32'd0);
         chk({tag, " restart abort data"}, 32'(rsp0.resp_data), 32'(v.exp));
      end
   endtask

   vec_t tbl [8];
   vec_t vr;
   logic [15:0] pat1;
   int lat;
   bit got;

   initial begin
      rsp0.resp_ready = 1'b0;
      rsp1.resp_ready = 1'b0;
      tbl[0] = mk(16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 10, 0, 0, 1'b1);
      tbl[1] = mk(16'h122C, 16'h1234, 16'h122C, 16'h1234, 16'h122C, 16'h122C, 0, 0, 0, 1'b0);
      tbl[2] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 50, 0, 1'b0);
      tbl[3] = mk(16'h5A3C, 16'h5A3C, 16'h5A3C, 16'h5A3C, 16'h5A3C, 16'h5A3C, 2, 0, 0, 1'b0);
      tbl[4] = mk(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hF0F0, 16'hF0F0, 1, 0, 0, 1'b0);
      tbl[5] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, PASS_T, 0, 1'b0);
      tbl[6] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 60, 1'b0);
      tbl[7] = mk(16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 0, 0, 0, 1'b0);

      #12;
      chk("reset sel", 32'(mux_sel0), 32'd0);
      chk("reset busy", 32'(busy0), 32'd0);
      chk("reset valid", 32'(rsp0.resp_valid), 32'd0);
      chk("reset data", 32'(rsp0.resp_data), 32'd0);
      reset_n = 1'b1;
      tick();

      // start together with abort in IDLE is refused
      start0 = 1'b1; abort0 = 1'b1;
      tick();
      start0 = 1'b0; abort0 = 1'b0;
      chk("start+abort busy", 32'(busy0), 32'd0);
      chk("start+abort sel", 32'(mux_sel0), 32'd0);

      for (int i = 0; i < 8; i++) run_pass(tbl[i], $sformatf("vec%0d", i));

      for (int r = 0; r < 6; r++) begin
         vr = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'h0000, $urandom_range(0, 4), 0, 0, 1'b0);
         vr.exp = maj_word(vr);
         run_pass(vr, $sformatf("rnd%0d", r));
      end

      for (int p = 0; p < 3; p++) begin
         pat1 = (p == 0) ? 16'h8001 : 16'($urandom);
         start1 = 1'b1;
         tick();
         start1 = 1'b0;
         chk("fast busy", 32'(busy1), 32'd1);
         lat = 0; got = 1'b0;
         for (int t = 1; t <= 40 && !got; t++) begin
            mux_out1 = (t <= 16) ? pat1[t - 1] : 1'($urandom);
            tick();
            if (rsp1.resp_valid) begin
               got = 1'b1;
               lat = t;
            end else if (t < 16) begin
               chk("fast sel", 32'(mux_sel1), 32'(t));
            end
         end
         chk("fast latency", 32'(lat), 32'd16);
         chk("fast data", 32'(rsp1.resp_data), 32'(pat1));
         rsp1.resp_ready = 1'b1;
         tick();
         rsp1.resp_ready = 1'b0;
         chk("fast hs valid", 32'(rsp1.resp_valid), 32'd0);
         chk("fast hs busy", 32'(busy1), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
